pmem_arbiter: RTL and testbench
===============================

# pmem_arbiter

Two-port physical-memory arbiter for the LC-3b split-cache hierarchy. It shares the single line-wide physical memory port between the instruction-cache miss path (I-side, read-only) and the data-side victim-cache path (D-side, read/write). It grants one requester at a time in round-robin order and latches the granted command. It returns the line data and a one-cycle response to the owner, and counts contention cycles for performance analysis.

## Interface
Parameters:
- ADDR_W, 16: byte address width (lc3b_word)
- DATA_W, 128: line width (lc3b_mem_data)
- CNT_W, 16: contention counter width

Ports:
- clk  in  1  sole clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous, active-high
- i_mem_read  in  1  I-side line read request
- i_mem_address  in  ADDR_W  I-side line address
- i_mem_resp  out  1  I-side completion pulse
- i_mem_rdata  out  DATA_W  I-side read data
- d_mem_read  in  1  D-side line read request
- d_mem_write  in  1  D-side line write request
- d_mem_address  in  ADDR_W  D-side line address
- d_mem_wdata  in  DATA_W  D-side write line
- d_mem_resp  out  1  D-side completion pulse
- d_mem_rdata  out  DATA_W  D-side read data
- pmem_read  out  1  physical memory read strobe
- pmem_write  out  1  physical memory write strobe
- pmem_address  out  ADDR_W  physical memory address
- pmem_wdata  out  DATA_W  physical memory write line
- pmem_rdata  in  DATA_W  physical memory read line
- pmem_resp  in  1  physical memory completion
- clr_stats  in  1  synchronous clear of contention_count
- busy  out  1  high in any SERVE state
- contention_count  out  CNT_W  saturating contention counter

## Operation
- States: IDLE, SERVE_I, SERVE_D.
- Define i_req = i_mem_read and d_req = d_mem_read | d_mem_write.
- **IDLE transitions**:
  - Only i_req: go to SERVE_I.
  - Only d_req: go to SERVE_D.
  - Both: grant the side not recorded in last_grant.
  - Neither: stay in IDLE.
- **Grant capture**: on the IDLE→SERVE edge, latch the winner's address, its op, and (D-side) its wdata into command registers. Update last_grant to the winner.
- **D-side op**: if d_mem_write is high, the op is write; otherwise it is read. d_mem_read and d_mem_write both high counts as a write.
- **SERVE_x**:
  - pmem_read/pmem_write/pmem_address/pmem_wdata are driven from the command registers, registered outputs with no combinational path from requester inputs.
  - Requester inputs that change during SERVE are ignored; requesters hold their request until their resp.
- **Completion**:
  - In SERVE_x with pmem_resp=1, assert x_mem_resp combinationally in that same cycle.
  - Next state is IDLE; IDLE always lasts at least one cycle.
- i_mem_rdata and d_mem_rdata both equal pmem_rdata at all times. Consumers qualify the data with their own resp.
- The non-owner resp is always 0. pmem_resp in IDLE is ignored.
- **Contention counter**:
  - Increments by 1 in any cycle where the state is SERVE_I with d_req=1, or SERVE_D with i_req=1.
  - Saturates at 2^CNT_W−1.
  - clr_stats=1 forces it to 0 at the next edge and takes priority over an increment.

## Timing
- **Reset values** (rst=1, asynchronous):
  - state=IDLE, last_grant=D (so the first tie goes to I), busy=0.
  - pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
  - contention_count=0; both resp outputs are 0.
- **Reset mid-transaction**: outputs drop immediately. The pending transaction is abandoned with no resp, and a pmem_resp arriving after reset is ignored.
- **Outputs in IDLE**: pmem strobes are 0 and address/wdata are 0.
- **Latency**: a request sampled in IDLE at edge N gives a pmem strobe high from cycle N+1. The resp appears in the same cycle as pmem_resp.
- **Best-case round trip**: 2 cycles, with pmem_resp in the first SERVE cycle.
- **Back-to-back**: the minimum gap between two pmem transactions is one IDLE cycle.
- **Simultaneous requests**: grants alternate strictly while both are held, so neither side waits more than one foreign transaction.

## Test plan
- **Reset**: assert rst mid-SERVE_D with pmem_write=1 → pmem_write, busy and contention_count drop to 0 in the same cycle without a clock edge, and d_mem_resp never pulses.
- **Single I read**: i_mem_read with address 0x1230, memory returning 0xAAAA…A after 3 cycles → pmem_read=1 and pmem_address=0x1230 from the cycle after the request, i_mem_resp pulses once with i_mem_rdata=0xAAAA…A, d_mem_resp stays 0.
- **D write**:
  - Stimulus: d_mem_write with address 0x4560 and wdata 0x0123…EF, then change d_mem_address to 0xFFFF during SERVE.
  - Response: pmem_write=1, pmem_address stays 0x4560, pmem_wdata=0x0123…EF until pmem_resp.
- **Tie after reset**: i_req and d_req asserted together, each held until its resp → I is served first and D second. contention_count=3 after 3 SERVE_I wait cycles, with D's wait in IDLE not counted.
- **Round-robin fairness**: both sides re-request immediately after each resp for 6 transactions → grant order I,D,I,D,I,D, with an IDLE cycle between each.
- **Counter boundaries**:
  - Preload near saturation (CNT_W=4, 20 contention cycles) → count holds at 15.
  - clr_stats in a contention cycle → count becomes 0.

Source files
------------

// File: rtl/pmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pmem_arbiter
//  Purpose  : Shares one line-wide physical memory port between the I-cache
//             miss path (read-only) and the D-side victim-cache path
//             (read/write). One requester is served at a time, alternating
//             on simultaneous requests, with a saturating counter of cycles
//             in which the non-owner was kept waiting.
//  Ports    : clk, rst            - clock, async active-high reset
//             i_mem_*             - I-side request / response
//             d_mem_*             - D-side request / response
//             pmem_*              - physical memory port
//             clr_stats           - synchronous clear of contention_count
//             busy                - high while a transaction is in service
//             contention_count    - saturating contention cycle counter
//  Revision : 1.0  initial release
// ============================================================================
module pmem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    // I-side (read only)
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_address,
    output logic              i_mem_resp,
    output logic [DATA_W-1:0] i_mem_rdata,
    // D-side (read / write)
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_address,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic              d_mem_resp,
    output logic [DATA_W-1:0] d_mem_rdata,
    // physical memory
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [DATA_W-1:0] pmem_wdata,
    input  logic [DATA_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    // statistics
    input  logic              clr_stats,
    output logic              busy,
    output logic [CNT_W-1:0]  contention_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    state_t              state_q;
    logic                last_grant_d_q;   // 1: D-side won the previous grant
    logic                pmem_read_q;
    logic                pmem_write_q;
    logic [ADDR_W-1:0]   pmem_address_q;
    logic [DATA_W-1:0]   pmem_wdata_q;
    logic [CNT_W-1:0]    cnt_q;

    logic w_i_req;
    logic w_d_req;
    logic w_grant_i;
    logic w_grant_d;
    logic w_contend;

    assign w_i_req = i_mem_read;
    assign w_d_req = d_mem_read | d_mem_write;

    // On a tie the side that did not win last time takes the grant.
    assign w_grant_i = w_i_req & (~w_d_req | last_grant_d_q);
    assign w_grant_d = w_d_req & (~w_i_req | ~last_grant_d_q);

    // A contention cycle: the other side is asking while someone is served.
    assign w_contend = ((state_q == ST_SERVE_I) & w_d_req) |
                       ((state_q == ST_SERVE_D) & w_i_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            last_grant_d_q <= 1'b1;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            cnt_q          <= '0;
        end else begin
            // Clear wins over a same-cycle increment.
            if (clr_stats) begin
                cnt_q <= '0;
            end else if (w_contend && (cnt_q != c_cnt_max)) begin
                cnt_q <= cnt_q + c_cnt_one;
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_grant_i) begin
                        state_q        <= ST_SERVE_I;
                        last_grant_d_q <= 1'b0;
                        pmem_read_q    <= 1'b1;
                        pmem_write_q   <= 1'b0;
                        pmem_address_q <= i_mem_address;
                        pmem_wdata_q   <= '0;
                    end else if (w_grant_d) begin
                        state_q        <= ST_SERVE_D;
                        last_grant_d_q <= 1'b1;
                        // A write request dominates a simultaneous read.
                        pmem_read_q    <= ~d_mem_write;
                        pmem_write_q   <= d_mem_write;
                        pmem_address_q <= d_mem_address;
                        pmem_wdata_q   <= d_mem_wdata;
                    end
                end
                ST_SERVE_I, ST_SERVE_D: begin
                    // The command registers hold until completion, so
                    // requester input changes during service are ignored.
                    if (pmem_resp) begin
                        state_q        <= ST_IDLE;
                        pmem_read_q    <= 1'b0;
                        pmem_write_q   <= 1'b0;
                        pmem_address_q <= '0;
                        pmem_wdata_q   <= '0;
                    end
                end
                default: begin
                    state_q        <= ST_IDLE;
                    pmem_read_q    <= 1'b0;
                    pmem_write_q   <= 1'b0;
                    pmem_address_q <= '0;
                    pmem_wdata_q   <= '0;
                end
            endcase
        end
    end

    assign pmem_read        = pmem_read_q;
    assign pmem_write       = pmem_write_q;
    assign pmem_address     = pmem_address_q;
    assign pmem_wdata       = pmem_wdata_q;
    assign busy             = (state_q != ST_IDLE);
    assign contention_count = cnt_q;

    // Completion is forwarded in the same cycle as pmem_resp.
    assign i_mem_resp  = (state_q == ST_SERVE_I) & pmem_resp;
    assign d_mem_resp  = (state_q == ST_SERVE_D) & pmem_resp;
    assign i_mem_rdata = pmem_rdata;
    assign d_mem_rdata = pmem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pmem_arbiter
//  Purpose  : Directed self-checking bench for pmem_arbiter. A second
//             instance with a 4-bit counter shares the stimulus so that
//             saturation can be observed.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pmem_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_mem_read;
    logic [ADDR_W-1:0] i_mem_address;
    logic              d_mem_read;
    logic              d_mem_write;
    logic [ADDR_W-1:0] d_mem_address;
    logic [DATA_W-1:0] d_mem_wdata;
    logic [DATA_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic              clr_stats;

    logic              i_mem_resp, d_mem_resp;
    logic [DATA_W-1:0] i_mem_rdata, d_mem_rdata;
    logic              pmem_read, pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [DATA_W-1:0] pmem_wdata;
    logic              busy;
    logic [15:0]       contention_count;

    logic              i4_resp, d4_resp;
    logic [DATA_W-1:0] i4_rdata, d4_rdata;
    logic              p4_read, p4_write;
    logic [ADDR_W-1:0] p4_address;
    logic [DATA_W-1:0] p4_wdata;
    logic              busy4;
    logic [3:0]        count4;

    int vectors    = 0;
    int miscompares = 0;

    localparam logic [DATA_W-1:0] c_line_a  = {32{4'hA}};
    localparam logic [DATA_W-1:0] c_line_wd = 128'h0123456789ABCDEF0123456789ABCDEF;

    always #5 clk = ~clk;

    pmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
        .i_mem_resp(i_mem_resp), .i_mem_rdata(i_mem_rdata),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
        .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
        .d_mem_resp(d_mem_resp), .d_mem_rdata(d_mem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .clr_stats(clr_stats), .busy(busy),
        .contention_count(contention_count)
    );

    pmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
        .i_mem_resp(i4_resp), .i_mem_rdata(i4_rdata),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
        .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
        .d_mem_resp(d4_resp), .d_mem_rdata(d4_rdata),
        .pmem_read(p4_read), .pmem_write(p4_write),
        .pmem_address(p4_address), .pmem_wdata(p4_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .clr_stats(clr_stats), .busy(busy4),
        .contention_count(count4)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_mem_read = 0; i_mem_address = '0;
        d_mem_read = 0; d_mem_write = 0; d_mem_address = '0; d_mem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 0; clr_stats = 0;
        #2;
        vectors++; if ({pmem_read, pmem_write} !== 2'b00) begin miscompares++; $display("FAIL rst_strobes got %b want 00", {pmem_read, pmem_write}); end
        vectors++; if (pmem_address !== 16'h0) begin miscompares++; $display("FAIL rst_addr got %h want 0000", pmem_address); end
        vectors++; if (pmem_wdata !== '0) begin miscompares++; $display("FAIL rst_wdata got %h want 0", pmem_wdata); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
        vectors++; if (contention_count !== 16'd0) begin miscompares++; $display("FAIL rst_count got %0d want 0", contention_count); end
        vectors++; if ({i_mem_resp, d_mem_resp} !== 2'b00) begin miscompares++; $display("FAIL rst_resp got %b want 00", {i_mem_resp, d_mem_resp}); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_i();
        i_mem_read = 1; i_mem_address = 16'h1230;
        tick();
        vectors++; if ({pmem_read, pmem_write} !== 2'b10) begin miscompares++; $display("FAIL i_strobe got %b want 10", {pmem_read, pmem_write}); end
        vectors++; if (pmem_address !== 16'h1230) begin miscompares++; $display("FAIL i_addr got %h want 1230", pmem_address); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL i_busy got %b want 1", busy); end
        vectors++; if (i_mem_resp !== 1'b0) begin miscompares++; $display("FAIL i_early_resp got %b want 0", i_mem_resp); end
        tick();
        tick();
        pmem_resp = 1; pmem_rdata = c_line_a;
        #1;
        vectors++; if (i_mem_resp !== 1'b1) begin miscompares++; $display("FAIL i_resp got %b want 1", i_mem_resp); end
        vectors++; if (i_mem_rdata !== c_line_a) begin miscompares++; $display("FAIL i_rdata got %h want %h", i_mem_rdata, c_line_a); end
        vectors++; if (d_mem_resp !== 1'b0) begin miscompares++; $display("FAIL i_dresp got %b want 0", d_mem_resp); end
        tick();
        i_mem_read = 0; pmem_resp = 0;
        #1;
        vectors++; if ({pmem_read, busy, i_mem_resp} !== 3'b000) begin miscompares++; $display("FAIL i_done got %b want 000", {pmem_read, busy, i_mem_resp}); end
        pmem_rdata = 128'h5;
        #1;
        vectors++; if (d_mem_rdata !== 128'h5) begin miscompares++; $display("FAIL rdata_pass got %h want 5", d_mem_rdata); end
    endtask

    task automatic test_d_write();
        tick();
        d_mem_write = 1; d_mem_address = 16'h4560; d_mem_wdata = c_line_wd;
        tick();
        d_mem_address = 16'hFFFF; d_mem_wdata = '0;
        for (int k = 0; k < 3; k++) begin
            vectors++; if ({pmem_read, pmem_write} !== 2'b01) begin miscompares++; $display("FAIL d_strobe[%0d] got %b want 01", k, {pmem_read, pmem_write}); end
            vectors++; if (pmem_address !== 16'h4560) begin miscompares++; $display("FAIL d_addr[%0d] got %h want 4560", k, pmem_address); end
            vectors++; if (pmem_wdata !== c_line_wd) begin miscompares++; $display("FAIL d_wdata[%0d] got %h want %h", k, pmem_wdata, c_line_wd); end
            if (k < 2) tick();
        end
        pmem_resp = 1;
        #1;
        vectors++; if ({i_mem_resp, d_mem_resp} !== 2'b01) begin miscompares++; $display("FAIL d_resp got %b want 01", {i_mem_resp, d_mem_resp}); end
        tick();
        d_mem_write = 0; pmem_resp = 0; d_mem_address = '0;
        #1;
        vectors++; if ({pmem_write, busy} !== 2'b00) begin miscompares++; $display("FAIL d_done got %b want 00", {pmem_write, busy}); end
    endtask

    task automatic test_reset_mid();
        tick();
        d_mem_write = 1; d_mem_address = 16'h0040; d_mem_wdata = c_line_wd;
        tick();
        i_mem_read = 1; i_mem_address = 16'h0080;
        tick();
        tick();
        vectors++; if (contention_count !== 16'd2) begin miscompares++; $display("FAIL mid_precount got %0d want 2", contention_count); end
        rst = 1'b1;
        #1;
        vectors++; if ({pmem_write, busy} !== 2'b00) begin miscompares++; $display("FAIL mid_rst got %b want 00", {pmem_write, busy}); end
        vectors++; if (contention_count !== 16'd0) begin miscompares++; $display("FAIL mid_count got %0d want 0", contention_count); end
        #1;
        rst = 1'b0;
        i_mem_read = 0; d_mem_write = 0;
        pmem_resp = 1;
        #1;
        vectors++; if (d_mem_resp !== 1'b0) begin miscompares++; $display("FAIL mid_dresp got %b want 0", d_mem_resp); end
        tick();
        vectors++; if ({d_mem_resp, busy} !== 2'b00) begin miscompares++; $display("FAIL mid_late got %b want 00", {d_mem_resp, busy}); end
        pmem_resp = 0;
    endtask

    task automatic test_tie();
        i_mem_read = 1; i_mem_address = 16'h0100;
        d_mem_read = 1; d_mem_address = 16'h0800;
        tick();
        vectors++; if ({pmem_read, pmem_address} !== {1'b1, 16'h0100}) begin miscompares++; $display("FAIL tie_first got %b/%h want 1/0100", pmem_read, pmem_address); end
        tick();
        tick();
        pmem_resp = 1;
        #1;
        vectors++; if ({i_mem_resp, d_mem_resp} !== 2'b10) begin miscompares++; $display("FAIL tie_iresp got %b want 10", {i_mem_resp, d_mem_resp}); end
        tick();
        i_mem_read = 0; pmem_resp = 0;
        vectors++; if (contention_count !== 16'd3) begin miscompares++; $display("FAIL tie_count got %0d want 3", contention_count); end
        tick();
        vectors++; if ({pmem_read, pmem_address} !== {1'b1, 16'h0800}) begin miscompares++; $display("FAIL tie_second got %b/%h want 1/0800", pmem_read, pmem_address); end
        vectors++; if (contention_count !== 16'd3) begin miscompares++; $display("FAIL tie_idle_count got %0d want 3", contention_count); end
        pmem_resp = 1;
        #1;
        vectors++; if ({i_mem_resp, d_mem_resp} !== 2'b01) begin miscompares++; $display("FAIL tie_dresp got %b want 01", {i_mem_resp, d_mem_resp}); end
        tick();
        d_mem_read = 0; pmem_resp = 0;
    endtask

    task automatic test_round_robin();
        logic owner_d;
        i_mem_read = 1; i_mem_address = 16'h2000;
        d_mem_read = 1; d_mem_address = 16'h3000;
        owner_d = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick();
            vectors++; if (pmem_address !== (owner_d ? 16'h3000 : 16'h2000)) begin miscompares++; $display("FAIL rr_addr[%0d] got %h want %h", t, pmem_address, owner_d ? 16'h3000 : 16'h2000); end
            pmem_resp = 1;
            #1;
            vectors++; if ({i_mem_resp, d_mem_resp} !== (owner_d ? 2'b01 : 2'b10)) begin miscompares++; $display("FAIL rr_resp[%0d] got %b want %b", t, {i_mem_resp, d_mem_resp}, owner_d ? 2'b01 : 2'b10); end
            tick();
            pmem_resp = 0;
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rr_gap[%0d] got %b want 0", t, busy); end
            owner_d = ~owner_d;
        end
        vectors++; if (contention_count !== 16'd9) begin miscompares++; $display("FAIL rr_count got %0d want 9", contention_count); end
        i_mem_read = 0; d_mem_read = 0;
    endtask

    task automatic test_counter();
        clr_stats = 1;
        tick();
        clr_stats = 0;
        vectors++; if ({contention_count, count4} !== 20'd0) begin miscompares++; $display("FAIL cnt_clr got %0d/%0d want 0/0", contention_count, count4); end
        i_mem_read = 1; i_mem_address = 16'h0010;
        d_mem_write = 1; d_mem_address = 16'h0020;
        tick();
        for (int c = 0; c < 10; c++) tick();
        vectors++; if ({contention_count, count4} !== {16'd10, 4'd10}) begin miscompares++; $display("FAIL cnt_mid got %0d/%0d want 10/10", contention_count, count4); end
        for (int c = 0; c < 10; c++) tick();
        vectors++; if (contention_count !== 16'd20) begin miscompares++; $display("FAIL cnt_20 got %0d want 20", contention_count); end
        vectors++; if (count4 !== 4'd15) begin miscompares++; $display("FAIL cnt_sat got %0d want 15", count4); end
        clr_stats = 1;
        tick();
        clr_stats = 0;
        vectors++; if ({contention_count, count4} !== 20'd0) begin miscompares++; $display("FAIL cnt_clr_busy got %0d/%0d want 0/0", contention_count, count4); end
        tick();
        vectors++; if ({contention_count, count4} !== {16'd1, 4'd1}) begin miscompares++; $display("FAIL cnt_resume got %0d/%0d want 1/1", contention_count, count4); end
        pmem_resp = 1;
        tick();
        i_mem_read = 0; d_mem_write = 0; pmem_resp = 0;
    endtask

    initial begin
        test_reset();
        test_single_i();
        test_d_write();
        test_reset_mid();
        test_tie();
        test_round_robin();
        test_counter();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
